prince_iter_ctrl: RTL
=====================

// Module: prince_iter_ctrl
// PURPOSE
//  Iterative PRINCE encrypt/decrypt sequencer. Reuses one forward round (prince_core) and one inverse round (prince_core1).
//  It also owns a middle stage (sbox -> M' -> invsbox), the round counter, RC selection and key whitening/alpha reflection.
//  It sits between the host block interface (valid/ready) and the round datapath.
//  One 64-bit block is processed per transaction; 12 cycles from accept to out_valid.
// PARAMETERS
//  ALPHA      64'hc0ac29b7c97c50dd  PRINCE alpha reflection constant (RCi ^ RC11-i)
//  LATCH_KEY  1                     1: key/decrypt captured at accept; 0: used live (caller holds stable)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    async active-low reset
//  in_valid   in   1    block + key + mode presented
//  in_ready   out  1    controller idle, can accept
//  decrypt    in   1    0 encrypt, 1 decrypt; sampled at accept
//  key        in   128  {k0[127:64], k1[63:0]}; sampled at accept
//  data_in    in   64   plaintext/ciphertext
//  out_valid  out  1    data_out holds a result
//  out_ready  in   1    consumer takes result
//  data_out   out  64   result, stable while out_valid && !out_ready
//  busy       out  1    high in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rnd=0, st_reg=0, data_out=0, out_valid=0, busy=0.
//    in_ready=1 after release. Reset mid-block aborts it with no output.
//  Key derivation at accept:
//    k0p = {k0[0],k0[63:1]} ^ {63'b0,k0[63]}.
//    enc: kw_in=k0, kw_out=k0p, kc=k1.   dec: kw_in=k0p, kw_out=k0, kc=k1^ALPHA.
//  RC table (64b hex), RC0..RC11:
//    RC0  0000000000000000  RC1  13198a2e03707344  RC2  a4093822299f31d0  RC3  082efa98ec4e6c89
//    RC4  452821e638d01377  RC5  be5466cf34e90c6c  RC6  7ef84f78fd955cb1  RC7  85840851f1ac43aa
//    RC8  c882d32f25323c54  RC9  64a51195e0e3610d  RC10 d3b5a399ca0c2399  RC11 c0ac29b7c97c50dd
//  FSM states and transitions; each state lasts 1 cycle unless noted:
//    IDLE : in_ready=1. On in_valid: st_reg<=data_in^kw_in^kc^RC0, rnd<=1, -> FWD.
//    FWD  : st_reg<=prince_core(st_reg,kc,RC[rnd]), rnd++. After rnd==5 -> MID.
//    MID  : st_reg<=invsbox(M'(sbox(st_reg))), rnd<=6, -> INV.
//           M' = PRINCE M-hat involution, i.e. linear_m without ShiftRows.
//    INV  : st_reg<=prince_core1(st_reg,kc,RC[rnd]), rnd++. After rnd==10 -> FIN.
//    FIN  : data_out<=st_reg^kc^RC11^kw_out, out_valid<=1, -> OUT.
//    OUT  : hold data_out/out_valid until out_ready=1; then out_valid<=0, -> IDLE.
//  Latency and throughput:
//    Accept edge = edge where in_valid&&in_ready. out_valid rises on the 12th following edge.
//    Minimum 14 cycles per block; one idle bubble between blocks.
//  rnd is 4 bits and only takes values 0..11; any other value (upset) forces IDLE.
//  in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored, not queued.
//  LATCH_KEY=1: key/decrypt changes after accept have no effect on the running block.
//  out_ready asserted while out_valid=0 has no effect. No combinational path in_valid->in_ready.
//  Round datapath is combinational; exactly one round result is registered per cycle.
// TESTING
//  T1 enc pt=0, k0=0, k1=0 -> data_out=818665aa0d02dfda; out_valid 12 edges after accept.
//  T2 enc pt=ffffffffffffffff, k=0 -> 604ae6ca03c20ada.
//     Also: pt=0, k0=ffffffffffffffff, k1=0 -> 9fb51935fc3df524.
//  T3 enc pt=0123456789abcdef, k0=0, k1=fedcba9876543210 -> ae25ad3ca8fa9ccf.
//     dec of that ct with same key -> 0123456789abcdef.
//  T4 back-pressure: hold out_ready=0 for 20 cycles after out_valid.
//     -> data_out stable, in_ready=0, extra in_valid ignored; release -> IDLE next cycle.
//  T5 pull rst_n low during INV (rnd=7) -> out_valid=0, data_out=0, busy=0 immediately.
//     After release, T1 vector passes with correct latency.
//  T6 toggle key/decrypt every cycle after accept (LATCH_KEY=1).
//     -> result equals T1/T3 expected; random enc/dec round-trip over 1000 vectors matches.

Source files
------------

// File: rtl/prince_iter_ctrl.sv
// prince_iter_ctrl: iterative PRINCE encrypt/decrypt sequencer. One forward round, the
// middle stage and one inverse round are reused; a block takes 12 edges from accept to out_valid.
module prince_iter_ctrl #(
    parameter logic [63:0] ALPHA     = 64'hc0ac29b7c97c50dd,
    parameter bit          LATCH_KEY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [63:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy,
    output logic [2:0]   dbg_state
);
    // Handshake: a transfer occurs on a rising edge where valid and ready are both high;
    // valid never waits on ready and ready never depends combinationally on valid.

    typedef enum logic [2:0] {
        IDLE = 3'd0, FWD = 3'd1, MID = 3'd2, INV = 3'd3, FIN = 3'd4, OUT = 3'd5
    } state_t;

    // Nibble v of the table sits at bits [4v +: 4].
    localparam logic [63:0] SBOX     = 64'h4d5e087619ca23fb;
    localparam logic [63:0] SBOX_INV = 64'h1ce5046a98df237b;

    state_t      state, state_next;
    logic [3:0]  rnd;
    logic [63:0] st_reg;
    logic [63:0] kc_q, kw_out_q;
    logic [63:0] k0, k1, k0p;
    logic [63:0] kw_in_live, kw_out_live, kc_live;
    logic [63:0] kc, kw_out;
    logic [63:0] rc_cur, sm, fwd_out, mid_out, inv_out;
    logic        rnd_upset;

    function automatic logic [63:0] rc(input logic [3:0] i);
        case (i)
            4'd1:    rc = 64'h13198a2e03707344;
            4'd2:    rc = 64'ha4093822299f31d0;
            4'd3:    rc = 64'h082efa98ec4e6c89;
            4'd4:    rc = 64'h452821e638d01377;
            4'd5:    rc = 64'hbe5466cf34e90c6c;
            4'd6:    rc = 64'h7ef84f78fd955cb1;
            4'd7:    rc = 64'h85840851f1ac43aa;
            4'd8:    rc = 64'hc882d32f25323c54;
            4'd9:    rc = 64'h64a51195e0e3610d;
            4'd10:   rc = 64'hd3b5a399ca0c2399;
            4'd11:   rc = 64'hc0ac29b7c97c50dd;
            default: rc = 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] sub_nibbles(input logic [63:0] x, input logic [63:0] tbl);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = tbl[{x[4*n +: 4], 2'b00} +: 4];
        return y;
    endfunction

    // M' is block-diagonal over 16-bit chunks: M0-hat on the outer chunks, M1-hat inside.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        logic [63:0] y;
        logic        acc;
        int          off;
        y = '0;
        for (int ch = 0; ch < 4; ch++) begin
            off = (ch == 0 || ch == 3) ? 1 : 0;
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 4; b++) begin
                    acc = 1'b0;
                    for (int i = 0; i < 4; i++)
                        if (((i + j + off) % 4) != b) acc = acc ^ x[16*ch + 4*i + b];
                    y[16*ch + 4*j + b] = acc;
                end
            end
        end
        return y;
    endfunction

    // Nibble p = 4*col + row counted from the MSB; row r rotates left by r columns.
    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int          src;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4*((c + 4 - r) % 4) + r : 4*((c + r) % 4) + r;
                y[63 - 4*(4*c + r) -: 4] = x[63 - 4*src -: 4];
            end
        end
        return y;
    endfunction

    assign k0          = key[127:64];
    assign k1          = key[63:0];
    assign k0p         = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
    assign kw_in_live  = decrypt ? k0p : k0;
    assign kw_out_live = decrypt ? k0 : k0p;
    assign kc_live     = decrypt ? (k1 ^ ALPHA) : k1;
    assign kc          = LATCH_KEY ? kc_q : kc_live;
    assign kw_out      = LATCH_KEY ? kw_out_q : kw_out_live;

    assign rc_cur  = rc(rnd);
    assign sm      = m_prime(sub_nibbles(st_reg, SBOX));
    assign fwd_out = shift_rows(sm, 1'b0) ^ rc_cur ^ kc;
    assign mid_out = sub_nibbles(sm, SBOX_INV);
    assign inv_out = sub_nibbles(m_prime(shift_rows(st_reg ^ rc_cur ^ kc, 1'b1)), SBOX_INV);

    assign rnd_upset = (rnd > 4'd11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rnd_upset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = FWD;
                FWD:     if (rnd == 4'd5) state_next = MID;
                MID:     state_next = INV;
                INV:     if (rnd == 4'd10) state_next = FIN;
                FIN:     state_next = OUT;
                OUT:     if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg   <= '0;
            rnd      <= '0;
            data_out <= '0;
            kc_q     <= '0;
            kw_out_q <= '0;
        end else if (rnd_upset) begin
            rnd <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st_reg   <= data_in ^ kw_in_live ^ kc_live ^ rc(4'd0);
                    rnd      <= 4'd1;
                    kc_q     <= kc_live;
                    kw_out_q <= kw_out_live;
                end
                FWD: begin
                    st_reg <= fwd_out;
                    rnd    <= rnd + 4'd1;
                end
                MID: begin
                    st_reg <= mid_out;
                    rnd    <= 4'd6;
                end
                INV: begin
                    st_reg <= inv_out;
                    rnd    <= rnd + 4'd1;
                end
                FIN:     data_out <= st_reg ^ kc ^ rc(4'd11) ^ kw_out;
                OUT:     if (out_ready) rnd <= '0;
                default: ;
            endcase
        end
    end
endmodule
